// File: rtl/uart_rx_async_if.sv
// Receive-side byte handshake between uart_rx_async and the UART register/FIFO layer.
//
// Handshake: rx_rdy high means rx_data and its error flags hold an unread frame.
// The consumer takes it by pulsing rx_read for exactly one clk while rx_rdy is high.
// rx_rdy falls on the next clk unless a new frame loads in that same clk.
// rx_read while rx_rdy is low has no effect. overflow is sticky until the next read.
interface uart_rx_async_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       rx_read;

  // Receiver side: drives the byte and its status.
  modport slave (
    output rx_data,
    output rx_rdy,
    output parity_err,
    output framing_err,
    output overflow,
    input  rx_read
  );

  // Consumer side: observes the byte and issues the read pulse.
  modport master (
    input  rx_data,
    input  rx_rdy,
    input  parity_err,
    input  framing_err,
    input  overflow,
    output rx_read
  );
endinterface

// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver, 16x oversampled, 7/8 data bits, optional parity, one stop bit.
// Optional feature macro: RX_MAJORITY_VOTE_EN -- each bit is the 2-of-3 majority of the
// synchronised line at sample counts 6, 7 and 8, decided at count 8. Without it a single
// read at count 7 is used.
// o_dbg_state exposes the receive FSM state for observation.
module uart_rx_async #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              baud16_pulse,
  input  logic              rx,
  input  logic              bit8,
  input  logic              parity_en,
  input  logic              odd_n_even,
  uart_rx_async_if.slave    bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_cnt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic                   r_par_acc;
  logic                   r_perr;
  logic                   r_armed;

  logic [7:0]             r_rx_data;
  logic                   r_rx_rdy;
  logic                   r_parity_err;
  logic                   r_framing_err;
  logic                   r_overflow;

  logic                   w_rx_s;
  logic                   w_sample;
  logic                   w_sample_pt;
  logic                   w_wrap;
  logic [2:0]             w_last_idx;
  logic                   w_par_expect;

  // Metastability chain; resets to the idle-high line level.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [3:0] DECIDE_CNT = 4'd8;

  logic r_vote6;
  logic r_vote7;

  // Capture the two early votes; the third is the live line at the decision tick.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_vote6 <= 1'b1;
      r_vote7 <= 1'b1;
    end else if (baud16_pulse) begin
      if (r_cnt == 4'd6) r_vote6 <= w_rx_s;
      if (r_cnt == 4'd7) r_vote7 <= w_rx_s;
    end
  end

  assign w_sample = (r_vote6 & r_vote7) | (r_vote6 & w_rx_s) | (r_vote7 & w_rx_s);
`else
  localparam logic [3:0] DECIDE_CNT = 4'd7;

  assign w_sample = w_rx_s;
`endif

  assign w_sample_pt  = baud16_pulse && (r_cnt == DECIDE_CNT);
  assign w_wrap       = baud16_pulse && (r_cnt == 4'd15);
  assign w_last_idx   = bit8 ? 3'd7 : 3'd6;
  // Parity bit value that makes the frame correct for the selected sense.
  assign w_par_expect = odd_n_even ^ r_par_acc;

  // Receive FSM, sample counter, shift register and the registered output handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'd0;
      r_par_acc     <= 1'b0;
      r_perr        <= 1'b0;
      r_armed       <= 1'b0;
      r_rx_data     <= 8'd0;
      r_rx_rdy      <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (baud16_pulse && (r_state != S_IDLE)) begin
        r_cnt <= r_cnt + 4'd1;
      end

      // A read consumes the byte and clears the sticky overflow; a load below may override rx_rdy.
      if (bus.rx_read && r_rx_rdy) begin
        r_rx_rdy   <= 1'b0;
        r_overflow <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // armed blocks a stuck-low line from being taken as a stream of start bits.
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_cnt     <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_par_acc <= 1'b0;
            r_perr    <= 1'b0;
            r_state   <= S_START;
          end
        end

        S_START: begin
          if (w_sample_pt && w_sample) begin
            r_state <= S_IDLE;
          end else if (w_wrap) begin
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_sample_pt) begin
            r_shift[r_bit_idx] <= w_sample;
            r_par_acc          <= r_par_acc ^ w_sample;
          end
          if (w_wrap) begin
            if (r_bit_idx == w_last_idx) begin
              r_state <= parity_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

        S_PARITY: begin
          if (w_sample_pt) begin
            r_perr <= (w_sample != w_par_expect);
          end
          if (w_wrap) begin
            r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_sample_pt) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            if (!r_rx_rdy || bus.rx_read) begin
              r_rx_data     <= {bit8 & r_shift[7], r_shift[6:0]};
              r_rx_rdy      <= 1'b1;
              r_framing_err <= ~w_sample;
              r_parity_err  <= r_perr & parity_en;
            end else begin
              // Unread byte is kept; the new frame is dropped and reported.
              r_overflow <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rx_rdy      = r_rx_rdy;
  assign bus.parity_err  = r_parity_err;
  assign bus.framing_err = r_framing_err;
  assign bus.overflow    = r_overflow;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: serial frames are driven bit by bit, the expected byte and flags
// are queued by a frame-level reference model, and a monitor pops and compares each presented byte.
module tb_uart_rx_async;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       baud16_pulse = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic [2:0] dbg_state;

  uart_rx_async_if bus ();

  uart_rx_async #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .baud16_pulse (baud16_pulse),
    .rx           (rx),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .odd_n_even   (odd_n_even),
    .bus          (bus),
    .o_dbg_state  (dbg_state)
  );

  // Clock and baud16 tick (one clk high every four clks, changed on the falling edge).
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud16_pulse = 1'b1;
      @(negedge clk);
      baud16_pulse = 1'b0;
    end
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_q[$];   // {framing_err, parity_err, rx_data}
  logic       mon_en = 1'b1;
  int         read_req = 0;
  int         read_served = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge baud16_pulse);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    ticks(16);
  endtask

  // Reference model: expected result computed from the frame contents alone.
  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pe, input logic odd,
                            input logic bad_par, input logic stop, input int low_after,
                            input logic expect_it);
    logic [7:0] m;
    logic       pbit;
    bit8       = b8;
    parity_en  = pe;
    odd_n_even = odd;
    m    = b8 ? d : {1'b0, d[6:0]};
    pbit = odd ^ (^m) ^ bad_par;
    if (expect_it) exp_q.push_back({~stop, pe & bad_par, m});
    drive_bit(1'b0);
    for (int i = 0; i < (b8 ? 8 : 7); i++) drive_bit(m[i]);
    if (pe) drive_bit(pbit);
    drive_bit(stop);
    if (low_after > 0) begin
      rx = 1'b0;
      ticks(16 * low_after);
      check("break_no_restart_state", dbg_state, 3'd0);
    end
    rx = 1'b1;
    ticks(4);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5000 && (exp_q.size() != 0 || bus.rx_rdy); i++) @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_rdy_low"}, bus.rx_rdy, 1'b0);
  endtask

  task automatic manual_read();
    read_req++;
    for (int i = 0; i < 100 && read_served != read_req; i++) @(negedge clk);
    check("manual_read_served", read_served, read_req);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever a byte is presented, then consumes it.
  initial begin
    logic [9:0] e;
    bus.rx_read = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_rdy && (mon_en || read_req != read_served)) begin
        if (mon_en) begin
          check("frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rx_data", bus.rx_data, e[7:0]);
            check("parity_err", bus.parity_err, e[8]);
            check("framing_err", bus.framing_err, e[9]);
            check("overflow_clear", bus.overflow, 1'b0);
          end
        end else begin
          read_served++;
        end
        bus.rx_read = 1'b1;
        @(negedge clk);
        bus.rx_read = 1'b0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_rdy", bus.rx_rdy, 1'b0);
    check("reset_parity_err", bus.parity_err, 1'b0);
    check("reset_framing_err", bus.framing_err, 1'b0);
    check("reset_overflow", bus.overflow, 1'b0);
    check("reset_state", dbg_state, 3'd0);
    aresetn = 1'b1;
    ticks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    drain("t1");

    // 7E1 0x53, correct then wrong parity
    send_frame(8'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    send_frame(8'h53, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    drain("t2");

    // Framing error followed by a line held low for three bit times
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    drain("t3");

    // Overflow: two frames without reading
    mon_en = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("ovf_rx_data", bus.rx_data, 8'h11);
    check("ovf_overflow", bus.overflow, 1'b1);
    check("ovf_rx_rdy", bus.rx_rdy, 1'b1);
    manual_read();
    check("ovf_cleared", bus.overflow, 1'b0);
    check("ovf_rdy_cleared", bus.rx_rdy, 1'b0);
    mon_en = 1'b1;

    // Short low glitch on the idle line
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(24);
    check("glitch_state", dbg_state, 3'd0);
    check("glitch_rx_rdy", bus.rx_rdy, 1'b0);
    check("glitch_parity_err", bus.parity_err, 1'b0);
    check("glitch_framing_err", bus.framing_err, 1'b0);
    check("glitch_overflow", bus.overflow, 1'b0);

`ifdef RX_MAJORITY_VOTE_EN
    // One-tick low spike inside data bit 3 must be voted out
    bit8 = 1'b1;
    parity_en = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx = 1'b1;
        ticks(7);
        rx = 1'b0;
        ticks(1);
        rx = 1'b1;
        ticks(8);
      end else begin
        drive_bit(1'b1);
      end
    end
    drive_bit(1'b1);
    ticks(4);
    drain("spike");
`endif

    // Reset in the middle of frame 0x81
    bit8 = 1'b1;
    parity_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    ticks(5);
    aresetn = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", bus.rx_data, 8'h00);
    check("midrst_rx_rdy", bus.rx_rdy, 1'b0);
    check("midrst_flags", {bus.parity_err, bus.framing_err, bus.overflow}, 3'b000);
    check("midrst_state", dbg_state, 3'd0);
    aresetn = 1'b1;
    ticks(4);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    drain("t6");

    // Randomised frames across formats and error cases
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) != 0), 0, 1'b1);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
